// File: rtl/set_input_conditioner_if.sv
// set_input_conditioner_if
//   Bundles the raw front-panel inputs and the conditioned time-set outputs
//   between the panel side (master) and the conditioner (slave).
//   btn_raw[5:0]  raw buttons: hour10, hour1, min10, min1, sec10, sec1
//   set_time_raw  raw slide switch
//   set_time      debounced switch level
//   hour10..sec1  one-cycle advance pulses
interface set_input_conditioner_if;
  logic [5:0] btn_raw;
  logic       set_time_raw;
  logic       set_time;
  logic       hour10;
  logic       hour1;
  logic       min10;
  logic       min1;
  logic       sec10;
  logic       sec1;

  modport master (
    output btn_raw, set_time_raw,
    input  set_time, hour10, hour1, min10, min1, sec10, sec1
  );

  modport slave (
    input  btn_raw, set_time_raw,
    output set_time, hour10, hour1, min10, min1, sec10, sec1
  );
endinterface

// File: rtl/set_input_conditioner.sv
// set_input_conditioner
//   Synchronises and debounces six digit-advance buttons and the set_time
//   switch, and turns each button press into a one-cycle advance pulse with
//   auto-repeat while held. Pulses only leave the block while the debounced
//   set_time level is high.
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    set_input_conditioner_if.slave (raw inputs in, level + pulses out)
//
// Button channel states:
//   state     | meaning
//   IDLE      | button released, waiting for a debounced press
//   HOLD_WAIT | press pulse issued, counting towards the first repeat
//   REPEATING | auto-repeat, one pulse every REPEAT_PERIOD cycles
module set_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input logic                     clk,
  input logic                     reset,
  set_input_conditioner_if.slave  bus
);

  localparam int MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P  = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CW     = $clog2(MAX_P);

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEATING} btn_state_t;

  // Channel 6 is the set_time switch, channels 5..0 the buttons.
  logic [6:0]    raw;
  logic [6:0]    sync1_q, sync2_q;
  logic [6:0]    lvl_q, lvl_d;
  logic [CW-1:0] db_cnt_q [7];
  logic [CW-1:0] db_cnt_d [7];

  btn_state_t    state_q [6];
  btn_state_t    state_d [6];
  logic [CW-1:0] rpt_cnt_q [6];
  logic [CW-1:0] rpt_cnt_d [6];
  logic [5:0]    fire;
  logic [5:0]    pulse_q;

  assign raw = {bus.set_time_raw, bus.btn_raw};

  always_comb begin
    for (int i = 0; i < 7; i++) begin
      lvl_d[i]    = lvl_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          lvl_d[i] = ~lvl_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // IDLE with a high level can only follow a rising edge, since every
  // path back to IDLE (release or reset) leaves the level low.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      state_d[i]   = state_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      fire[i]      = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (lvl_q[i]) begin
            fire[i]      = 1'b1;
            state_d[i]   = HOLD_WAIT;
            rpt_cnt_d[i] = '0;
          end
        end
        HOLD_WAIT: begin
          if (!lvl_q[i]) begin
            state_d[i] = IDLE;
          end else if (rpt_cnt_q[i] == RD_LAST) begin
            fire[i]      = 1'b1;
            rpt_cnt_d[i] = '0;
            state_d[i]   = REPEATING;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + CW'(1);
          end
        end
        REPEATING: begin
          if (!lvl_q[i]) begin
            state_d[i] = IDLE;
          end else if (rpt_cnt_q[i] == RP_LAST) begin
            fire[i]      = 1'b1;
            rpt_cnt_d[i] = '0;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + CW'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      pulse_q <= '0;
      for (int i = 0; i < 7; i++) db_cnt_q[i] <= '0;
      for (int i = 0; i < 6; i++) begin
        state_q[i]   <= IDLE;
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      // Gate with the set_time level that is visible in the pulse cycle.
      pulse_q <= fire & {6{lvl_d[6]}};
      for (int i = 0; i < 7; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int i = 0; i < 6; i++) begin
        state_q[i]   <= state_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end

  assign bus.set_time = lvl_q[6];
  assign bus.hour10   = pulse_q[5];
  assign bus.hour1    = pulse_q[4];
  assign bus.min10    = pulse_q[3];
  assign bus.min1     = pulse_q[2];
  assign bus.sec10    = pulse_q[1];
  assign bus.sec1     = pulse_q[0];

endmodule

// File: tb/tb_set_input_conditioner.sv
// tb_set_input_conditioner
//   Directed scenarios followed by random button/switch activity. A reference
//   model predicts set_time every cycle and the cycles in which pulses should
//   appear; a monitor compares the DUT against those predictions.
module tb_set_input_conditioner;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clk;
  logic reset;
  set_input_conditioner_if bus ();

  set_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [5:0] mask;
  } ev_t;

  ev_t  ev_q[$];
  bit   st_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   pulses_seen = 0;

  // Reference model: synchroniser delay, windowed debounce (level flips once
  // the last DB synchronised samples all disagree with it), and pulse times
  // derived from how long the debounced level has been high.
  logic [6:0] m_s1, m_s2, m_lvl;
  logic [3:0] m_hist [7];
  int         m_hist_n [7];
  int         m_age [6];

  always @(posedge clk) begin
    logic [6:0] s2_old, lvl_old;
    logic [5:0] mask;
    bit         fire;
    cyc++;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      for (int i = 0; i < 7; i++) begin m_hist[i] = '0; m_hist_n[i] = 0; end
      for (int i = 0; i < 6; i++) m_age[i] = 0;
      st_q.push_back(1'b0);
    end else begin
      s2_old  = m_s2;
      m_s2    = m_s1;
      m_s1    = {bus.set_time_raw, bus.btn_raw};
      lvl_old = m_lvl;
      for (int i = 0; i < 7; i++) begin
        m_hist[i]   = {m_hist[i][2:0], s2_old[i]};
        m_hist_n[i] = (m_hist_n[i] < DB) ? m_hist_n[i] + 1 : DB;
        if (m_hist_n[i] == DB && m_hist[i] == (lvl_old[i] ? 4'b0000 : 4'b1111)) begin
          m_lvl[i]    = ~lvl_old[i];
          m_hist_n[i] = 0;
        end
      end
      mask = '0;
      for (int i = 0; i < 6; i++) begin
        if (lvl_old[i]) begin
          m_age[i]++;
          fire = (m_age[i] == 1) ||
                 (m_age[i] > RD && ((m_age[i] - 1 - RD) % RP) == 0);
          if (fire && m_lvl[6]) mask[i] = 1'b1;
        end else begin
          m_age[i] = 0;
        end
      end
      st_q.push_back(m_lvl[6]);
      if (mask != 0) ev_q.push_back('{cyc: cyc, mask: mask});
    end
  end

  always @(negedge clk) begin
    logic [5:0] dmask;
    bit         e;
    ev_t        ev;
    if (cyc > 0) begin
      tests++;
      if (st_q.size() == 0) begin
        fails++;
        $display("FAIL set_time_queue cycle %0d: no expected value queued", cyc);
      end else begin
        e = st_q.pop_front();
        if (bus.set_time !== e) begin
          fails++;
          $display("FAIL set_time cycle %0d: got %b expected %b", cyc, bus.set_time, e);
        end
      end
      dmask = {bus.hour10, bus.hour1, bus.min10, bus.min1, bus.sec10, bus.sec1};
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        ev = ev_q.pop_front();
        tests++;
        fails++;
        $display("FAIL missed_pulse cycle %0d: got none expected mask %b", ev.cyc, ev.mask);
      end
      if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
        ev = ev_q.pop_front();
        tests++;
        pulses_seen++;
        if (dmask !== ev.mask) begin
          fails++;
          $display("FAIL pulse_mask cycle %0d: got %b expected %b", cyc, dmask, ev.mask);
        end
      end else if (dmask !== 6'b0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse cycle %0d: got %b expected 000000", cyc, dmask);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.btn_raw = '0;
    bus.set_time_raw = 1'b0;
    step(3);
    reset = 1'b0;

    // Switch on, then nothing pressed.
    bus.set_time_raw = 1'b1;
    step(12);

    // Short glitch on sec1.
    bus.btn_raw[0] = 1'b1; step(3);
    bus.btn_raw[0] = 1'b0; step(12);

    // Long hold on hour10 with release.
    bus.btn_raw[5] = 1'b1; step(40);
    bus.btn_raw[5] = 1'b0; step(20);

    // min1 held while the switch is off, switched on mid-hold.
    bus.set_time_raw = 1'b0; step(12);
    bus.btn_raw[2] = 1'b1; step(12);
    bus.set_time_raw = 1'b1; step(18);
    bus.btn_raw[2] = 1'b0; step(15);

    // Coincident presses.
    bus.btn_raw[4] = 1'b1; bus.btn_raw[1] = 1'b1; step(25);
    bus.btn_raw = '0; step(12);

    // Reset during auto-repeat with the button still held.
    bus.btn_raw[3] = 1'b1; step(22);
    reset = 1'b1; step(1);
    reset = 1'b0; step(25);
    bus.btn_raw = '0; step(12);

    // Same, but the switch drops during reset so the fresh press is gated off.
    bus.btn_raw[3] = 1'b1; step(22);
    reset = 1'b1; bus.set_time_raw = 1'b0; step(1);
    reset = 1'b0; step(15);
    bus.set_time_raw = 1'b1; step(25);
    bus.btn_raw = '0; step(12);

    // Random activity: mostly long holds, occasional glitches and resets.
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 6; b++)
        if ($urandom_range(0, 14) == 0) bus.btn_raw[b] = ~bus.btn_raw[b];
      if ($urandom_range(0, 59) == 0) bus.set_time_raw = ~bus.set_time_raw;
      reset = ($urandom_range(0, 699) == 0);
      step(1);
    end
    reset = 1'b0;
    bus.btn_raw = '0;
    step(30);

    #1;
    tests++;
    if (ev_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_pulses: got %0d outstanding expected 0", ev_q.size());
    end
    tests++;
    if (pulses_seen < 20) begin
      fails++;
      $display("FAIL pulse_activity: got %0d pulses expected at least 20", pulses_seen);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
